// File: rtl/ct_merge_pkg.sv
// Shared types and helpers for the ct interconnect merge/split nodes.
package ct_merge_pkg;

   typedef enum logic {
      CT_IDLE   = 1'b0,
      CT_LOCKED = 1'b1
   } ct_arb_state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned ct_clog2_min1(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/ct_merge_if.sv
// Flow-tagged valid/ready bundle between NI sources, the merge node and one sink.
interface ct_merge_if #(
   parameter int unsigned NI = 2,
   parameter int unsigned WO = 1,
   parameter int unsigned WF = 1
);
   logic [NI*WO-1:0] i_data;
   logic [NI-1:0]    i_valid;
   logic [NI*WF-1:0] i_flow;
   logic [NI-1:0]    i_eop;
   logic [NI-1:0]    o_ready;
   logic [WO-1:0]    o_data;
   logic             o_valid;
   logic [WF-1:0]    o_flow;
   logic             o_eop;
   logic             i_ready;

   modport slave (
      input  i_data, i_valid, i_flow, i_eop, i_ready,
      output o_ready, o_data, o_valid, o_flow, o_eop
   );

   modport master (
      output i_data, i_valid, i_flow, i_eop, i_ready,
      input  o_ready, o_data, o_valid, o_flow, o_eop
   );
endinterface

// File: rtl/ct_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after ptr, wrapping.
module ct_rr_arbiter
   import ct_merge_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned WS = ct_clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [WS-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [WS-1:0] gnt_idx,
   output logic          any
);

   // Two passes: indices above ptr first, then the wrapped range 0..ptr.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!any && req[j] && (j > 32'(ptr))) begin
            any           = 1'b1;
            gnt_idx       = WS'(j);
            gnt_onehot[j] = 1'b1;
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!any && req[j] && (j <= 32'(ptr))) begin
            any           = 1'b1;
            gnt_idx       = WS'(j);
            gnt_onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ct_merge.sv
// N-to-1 packet merge node: round-robin grant held until the winner's EOP beat transfers.
module ct_merge
   import ct_merge_pkg::*;
#(
   parameter int unsigned NI = 2,
   parameter int unsigned WO = 1,
   parameter int unsigned WF = 1
) (
   input  logic       clk,
   input  logic       reset,
   ct_merge_if.slave  bus
);

   localparam int unsigned   WS       = ct_clog2_min1(NI);
   localparam logic [WS-1:0] LAST_RST = WS'(NI - 1);

   ct_arb_state_t state, state_nxt;
   logic [WS-1:0] lock_idx, lock_nxt;
   logic [WS-1:0] last_idx, last_nxt;
   logic          stall_q;

   logic [NI-1:0] gnt_onehot;
   logic [WS-1:0] gnt_idx;
   logic          gnt_any;

   logic [NI-1:0] sel_onehot;
   logic [WS-1:0] sel_idx;
   logic          sel_vld;
   logic          sel_valid_in;
   logic          sel_eop;
   logic [WO-1:0] sel_data;
   logic [WF-1:0] sel_flow;
   logic          xfer;

   ct_rr_arbiter #(.N(NI), .WS(WS)) u_arb (
      .req        (bus.i_valid),
      .ptr        (last_idx),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   // Selection: locked input wins regardless of other valids.
   always_comb begin
      sel_idx    = gnt_idx;
      sel_vld    = gnt_any;
      sel_onehot = gnt_onehot;
      if (state == CT_LOCKED) begin
         sel_idx    = lock_idx;
         sel_vld    = 1'b1;
         sel_onehot = '0;
         for (int unsigned j = 0; j < NI; j++) begin
            if (32'(lock_idx) == j) sel_onehot[j] = 1'b1;
         end
      end
   end

   // AND-OR output mux driven by the one-hot select.
   always_comb begin
      sel_data     = '0;
      sel_flow     = '0;
      sel_eop      = 1'b0;
      sel_valid_in = 1'b0;
      for (int unsigned j = 0; j < NI; j++) begin
         if (sel_onehot[j]) begin
            sel_data     = sel_data | bus.i_data[WO*j +: WO];
            sel_flow     = sel_flow | bus.i_flow[WF*j +: WF];
            sel_eop      = sel_eop | bus.i_eop[j];
            sel_valid_in = sel_valid_in | bus.i_valid[j];
         end
      end
   end

   always_comb begin
      bus.o_data  = sel_data;
      bus.o_flow  = sel_flow;
      bus.o_eop   = sel_eop;
      bus.o_valid = !reset && sel_vld && sel_valid_in;
      bus.o_ready = reset ? '0 : (sel_onehot & {NI{bus.i_ready}});
   end

   assign xfer = bus.o_valid && bus.i_ready;

   // Next-state: a single-beat winner stays IDLE, anything else locks the grant.
   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_idx;
      last_nxt  = last_idx;
      case (state)
         CT_IDLE: begin
            if (gnt_any) begin
               if (xfer && sel_eop) begin
                  last_nxt = gnt_idx;
               end else begin
                  state_nxt = CT_LOCKED;
                  lock_nxt  = gnt_idx;
               end
            end
         end
         CT_LOCKED: begin
            if (xfer && sel_eop) begin
               state_nxt = CT_IDLE;
               last_nxt  = lock_idx;
            end
         end
         default: state_nxt = CT_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CT_IDLE;
         lock_idx <= '0;
         last_idx <= LAST_RST;
         stall_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         lock_idx <= lock_nxt;
         last_idx <= last_nxt;
         stall_q  <= bus.o_valid && !bus.i_ready;
      end
   end

   // A stalled beat must stay offered until it is accepted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(stall_q && !bus.o_valid && (state == CT_LOCKED)))
            else $error("valid withdrawn");
         assert (!sel_vld || (32'(sel_idx) < NI))
            else $error("sel out of range: %0d", sel_idx);
      end
   end

endmodule

// File: tb/tb_ct_merge.sv
// Directed bench for ct_merge at NI=3, NI=2 and NI=1 (random protocol-legal traffic).
module tb_ct_merge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset3, reset2, reset1;

   ct_merge_if #(.NI(3), .WO(8), .WF(4)) m3 ();
   ct_merge_if #(.NI(2), .WO(8), .WF(4)) m2 ();
   ct_merge_if #(.NI(1), .WO(8), .WF(2)) m1 ();

   ct_merge #(.NI(3), .WO(8), .WF(4)) dut3 (.clk(clk), .reset(reset3), .bus(m3.slave));
   ct_merge #(.NI(2), .WO(8), .WF(4)) dut2 (.clk(clk), .reset(reset2), .bus(m2.slave));
   ct_merge #(.NI(1), .WO(8), .WF(2)) dut1 (.clk(clk), .reset(reset1), .bus(m1.slave));

   int errors = 0;
   int checks = 0;
   int exp_g [5] = '{0, 1, 2, 0, 1};

   logic [7:0]  d1;
   logic [1:0]  f1;
   logic        v1, r1, e1, hold1;
   logic [10:0] exp_q [$];
   logic [10:0] got_q [$];
   int          nq;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset3 = 1'b1; reset2 = 1'b1; reset1 = 1'b1;
      m3.i_data = '0; m3.i_valid = '0; m3.i_flow = '0; m3.i_eop = '0; m3.i_ready = 1'b1;
      m2.i_data = '0; m2.i_valid = '0; m2.i_flow = '0; m2.i_eop = '0; m2.i_ready = 1'b1;
      m1.i_data = '0; m1.i_valid = '0; m1.i_flow = '0; m1.i_eop = '0; m1.i_ready = 1'b0;

      // Reset holds outputs low even with requests present
      #2;
      m3.i_valid = 3'b111;
      m3.i_eop   = 3'b111;
      #1;
      chk("rst_valid", 32'(m3.o_valid), 32'(0));
      chk("rst_ready", 32'(m3.o_ready), 32'(0));
      tick();
      tick();
      reset3 = 1'b0; reset2 = 1'b0; reset1 = 1'b0;

      // NI=3 fairness with single-beat packets
      m3.i_data = {8'hA2, 8'hA1, 8'hA0};
      m3.i_flow = {4'd3, 4'd2, 4'd1};
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("rr_ready", 32'(m3.o_ready), 32'(1) << exp_g[k]);
         chk("rr_flow", 32'(m3.o_flow), 32'(exp_g[k] + 1));
         chk("rr_data", 32'(m3.o_data), 32'(8'hA0) + 32'(exp_g[k]));
         tick();
      end

      // Async reset while input2 holds the lock on beat 2
      m3.i_valid = 3'b100;
      m3.i_eop   = 3'b000;
      m3.i_data  = {8'hC1, 8'hA1, 8'hA0};
      #1;
      chk("lk_b1_ready", 32'(m3.o_ready), 32'(3'b100));
      chk("lk_b1_data", 32'(m3.o_data), 32'(8'hC1));
      tick();
      m3.i_data  = {8'hC2, 8'hA1, 8'hA0};
      m3.i_valid = 3'b111;
      #1;
      chk("lk_b2_ready", 32'(m3.o_ready), 32'(3'b100));
      chk("lk_b2_data", 32'(m3.o_data), 32'(8'hC2));
      #2;
      reset3 = 1'b1;
      #1;
      chk("arst_valid", 32'(m3.o_valid), 32'(0));
      chk("arst_ready", 32'(m3.o_ready), 32'(0));
      tick();
      reset3    = 1'b0;
      m3.i_eop  = 3'b111;
      #1;
      chk("post_rst_ready", 32'(m3.o_ready), 32'(3'b001));
      chk("post_rst_flow", 32'(m3.o_flow), 32'(1));
      tick();
      chk("post_rst_next", 32'(m3.o_ready), 32'(3'b010));
      m3.i_valid = 3'b000;

      // NI=2: 4-beat packet on input0 keeps input1 waiting
      m2.i_flow  = {4'd7, 4'd3};
      m2.i_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         m2.i_data = {8'h55, 8'(8'h10 + k)};
         m2.i_eop  = {1'b1, (k == 3)};
         #1;
         chk("pkt_ready", 32'(m2.o_ready), 32'(2'b01));
         chk("pkt_data", 32'(m2.o_data), 32'(8'h10 + k));
         chk("pkt_eop", 32'(m2.o_eop), 32'(k == 3));
         tick();
      end
      m2.i_valid = 2'b10;
      #1;
      chk("pkt_next_ready", 32'(m2.o_ready), 32'(2'b10));
      chk("pkt_next_data", 32'(m2.o_data), 32'(8'h55));
      chk("pkt_next_flow", 32'(m2.o_flow), 32'(7));
      tick();
      m2.i_valid = 2'b00;

      // Downstream stall: grant and data held on input1
      m2.i_ready = 1'b0;
      m2.i_valid = 2'b10;
      m2.i_data  = {8'h66, 8'h77};
      m2.i_eop   = 2'b11;
      #1;
      chk("stall_valid", 32'(m2.o_valid), 32'(1));
      chk("stall_data", 32'(m2.o_data), 32'(8'h66));
      chk("stall_ready", 32'(m2.o_ready), 32'(0));
      tick();
      m2.i_valid = 2'b11;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("stall_hold_data", 32'(m2.o_data), 32'(8'h66));
         chk("stall_hold_ready", 32'(m2.o_ready), 32'(0));
         tick();
      end
      m2.i_ready = 1'b1;
      #1;
      chk("stall_rel_ready", 32'(m2.o_ready), 32'(2'b10));
      chk("stall_rel_data", 32'(m2.o_data), 32'(8'h66));
      tick();
      chk("stall_after_ready", 32'(m2.o_ready), 32'(2'b01));
      chk("stall_after_data", 32'(m2.o_data), 32'(8'h77));
      tick();
      m2.i_valid = 2'b00;

      // Mid-packet bubble on input0 blocks input1 until eop
      m2.i_valid = 2'b01;
      m2.i_data  = {8'h99, 8'h21};
      m2.i_eop   = 2'b10;
      #1;
      chk("bub_b1_ready", 32'(m2.o_ready), 32'(2'b01));
      chk("bub_b1_data", 32'(m2.o_data), 32'(8'h21));
      tick();
      m2.i_valid = 2'b11;
      m2.i_data  = {8'h99, 8'h22};
      #1;
      chk("bub_b2_ready", 32'(m2.o_ready), 32'(2'b01));
      chk("bub_b2_data", 32'(m2.o_data), 32'(8'h22));
      tick();
      m2.i_valid = 2'b10;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("bub_gap_valid", 32'(m2.o_valid), 32'(0));
         chk("bub_gap_ready", 32'(m2.o_ready), 32'(2'b01));
         tick();
      end
      m2.i_valid = 2'b11;
      m2.i_data  = {8'h99, 8'h23};
      m2.i_eop   = 2'b11;
      #1;
      chk("bub_b3_ready", 32'(m2.o_ready), 32'(2'b01));
      chk("bub_b3_data", 32'(m2.o_data), 32'(8'h23));
      chk("bub_b3_eop", 32'(m2.o_eop), 32'(1));
      tick();
      m2.i_valid = 2'b10;
      #1;
      chk("bub_next_ready", 32'(m2.o_ready), 32'(2'b10));
      chk("bub_next_data", 32'(m2.o_data), 32'(8'h99));
      tick();
      m2.i_valid = 2'b00;

      // NI=1 random traffic; a stalled beat is held until accepted
      hold1 = 1'b0;
      v1 = 1'b0; d1 = '0; f1 = '0; e1 = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         if (!hold1) begin
            v1 = 1'($urandom_range(0, 1));
            d1 = 8'($urandom);
            f1 = 2'($urandom);
            e1 = 1'($urandom_range(0, 1));
         end
         r1 = 1'($urandom_range(0, 1));
         m1.i_valid = v1;
         m1.i_data  = d1;
         m1.i_flow  = f1;
         m1.i_eop   = e1;
         m1.i_ready = r1;
         #1;
         chk("p1_valid", 32'(m1.o_valid), 32'(v1));
         if (v1) chk("p1_beat", 32'({m1.o_ready, m1.o_eop, m1.o_flow, m1.o_data}),
                     32'({r1, e1, f1, d1}));
         if (v1 && r1) exp_q.push_back({e1, f1, d1});
         if (m1.o_valid && m1.i_ready) got_q.push_back({m1.o_eop, m1.o_flow, m1.o_data});
         hold1 = v1 && !r1;
         tick();
      end
      m1.i_valid = 1'b0;
      chk("p1_count", 32'(got_q.size()), 32'(exp_q.size()));
      nq = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nq; i++) begin
         chk("p1_sb", 32'(got_q[i]), 32'(exp_q[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
